// File: rtl/adder_5bit_pkg.sv
// Shared types for the registered 5-bit ALU adder.
// Operand width, word type and the status-flag bundle.
package adder_5bit_pkg;

  localparam int ADD_W = 5;

  typedef logic [ADD_W-1:0] word_t;

  typedef struct packed {
    logic cf;
    logic sf;
    logic zf;
  } flags_t;

  localparam flags_t FLAGS_RST = '0;

endpackage

// File: rtl/adder_5bit_unit_fa_cell.sv
// One-bit full adder cell.
// Chained by adder_5bit_unit to form the ripple carry path.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_5bit_unit.sv
// Registered 5-bit ripple-carry adder with carry/sign/zero flags.
// ADDER_5BIT_PIPE_EN adds a reset input register stage (latency 2).
module adder_5bit_unit
  import adder_5bit_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             cf,
  output logic             sf,
  output logic             zf
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

`ifdef ADDER_5BIT_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end
`else
  assign a_q   = a;
  assign b_q   = b;
  assign cin_q = cin;
`endif

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Zero flag looks only at the sum; the carry-out is ignored.
  flags_t flags_d;
  flags_t flags_q;

  always_comb begin
    flags_d    = FLAGS_RST;
    flags_d.cf = carry[WIDTH];
    flags_d.sf = sum[WIDTH-1];
    flags_d.zf = (sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s       <= '0;
      cout    <= 1'b0;
      flags_q <= FLAGS_RST;
    end else begin
      s       <= sum;
      cout    <= carry[WIDTH];
      flags_q <= flags_d;
    end
  end

  assign cf = flags_q.cf;
  assign sf = flags_q.sf;
  assign zf = flags_q.zf;

endmodule

// File: tb/tb_adder_5bit_unit.sv
// Scoreboard bench for adder_5bit_unit: directed vectors,
// mid-stream reset pulses and an exhaustive operand sweep.
module tb_adder_5bit_unit;

`ifdef ADDER_5BIT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [8:0] v;
    string      tag;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic       cin = 1'b0;
  logic [4:0] s;
  logic       cout;
  logic       cf;
  logic       sf;
  logic       zf;

  int  errors = 0;
  int  checks = 0;
  sb_t sb_q[$];

  adder_5bit_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout),
    .cf    (cf),
    .sf    (sf),
    .zf    (zf)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_model(
    input logic [4:0] ra,
    input logic [4:0] rb,
    input logic       rc
  );
    logic [5:0] t;
    t = {1'b0, ra} + {1'b0, rb} + {5'b0, rc};
    return {t[4:0], t[5], t[5], t[4], (t[4:0] == 5'd0)};
  endfunction

  function automatic logic [8:0] obs();
    return {s, cout, cf, sf, zf};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: got s/cout/cf/sf/zf=%b required %b", tag, o, exp);
    end
  endtask

  // Results still in flight in the input stage after reset are 0+0+0.
  task automatic prefill();
    for (int i = 0; i < LAT - 1; i++)
      sb_q.push_back('{v: ref_model(5'd0, 5'd0, 1'b0), tag: "post_rst"});
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic       sc,
    input logic [8:0] exp,
    input string      tag
  );
    sb_t e;
    a   = sa;
    b   = sb;
    cin = sc;
    sb_q.push_back('{v: exp, tag: tag});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, e.v);
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    a     = 5'($urandom);
    b     = 5'($urandom);
    cin   = 1'($urandom);
    rst_n = 1'b0;
    #1;
    check({tag, "_async"}, 9'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    check({tag, "_hold"}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prefill();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    pulse_reset("reset");

    step(5'b10101, 5'b01100, 1'b0, {5'b00001, 4'b1100}, "v_21_12");
    step(5'b11100, 5'b00000, 1'b1, {5'b11101, 4'b0010}, "v_28_0_c");
    step(5'b00001, 5'b00111, 1'b0, {5'b01000, 4'b0000}, "v_1_7");
    step(5'b11111, 5'b00000, 1'b1, {5'b00000, 4'b1101}, "zero_wrap");
    step(5'b00000, 5'b00000, 1'b0, {5'b00000, 4'b0001}, "zero_plain");
    step(5'b11111, 5'b11111, 1'b1, {5'b11111, 4'b1110}, "max");
    step(5'b01111, 5'b00000, 1'b1, {5'b10000, 4'b0010}, "sign_edge");

    pulse_reset("mid_rst");

    step(5'b00011, 5'b00100, 1'b1, {5'b01000, 4'b0000}, "after_rst");
    step(5'b10000, 5'b10000, 1'b0, {5'b00000, 4'b1101}, "msb_carry");

    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          step(5'(ia), 5'(ib), 1'(ic),
               ref_model(5'(ia), 5'(ib), 1'(ic)), "sweep");
        end
      end
      if (ia == 16) pulse_reset("sweep_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
